// File: rtl/store_queue.sv
// store_queue: in-order store buffer between the store packer and the data memory write port.
// Latency: a store accepted in cycle N is presented on mem_* in cycle N+1 at the earliest.
// Backpressure: st_ready drops when full or while a fence drains; mem_* holds while mem_ready is low.
//
// Optional feature macro: STORE_FWD_EN
//   defined   -> loads forward pending store bytes (youngest match per byte), ld_conflict = 0
//   undefined -> ld_data = 0, ld_conflict = |ld_mask (load stalls until matching stores drain)
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   st_valid/st_ready           store offer handshake; st_addr/st_data/st_we carry the store
//   fence                       blocks new stores until every pending store has retired
//   ld_addr -> ld_mask/ld_data  combinational lookup of pending bytes for a load word address
//   ld_conflict                 load must stall
//   mem_valid/mem_ready         drain handshake; mem_addr/mem_din/mem_we carry the head entry
//   empty, count                occupancy status

module store_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // store side
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    input  logic [DATA_W/8-1:0]      st_we,
    input  logic                     fence,
    // load lookup
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic [DATA_W/8-1:0]      ld_mask,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_conflict,
    // drain to memory
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_din,
    output logic [DATA_W/8-1:0]      mem_we,
    // status
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int NB    = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              fence_hold_q, fence_hold_d;

    logic [ADDR_W-1:0] ent_addr_q [DEPTH];
    logic [ADDR_W-1:0] ent_addr_d [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];
    logic [NB-1:0]     ent_we_q   [DEPTH];
    logic [NB-1:0]     ent_we_d   [DEPTH];

    logic              hold_now;
    logic              st_fire;
    logic              enq;
    logic              deq;

    // ------------------------------------------------------------------
    // Handshakes and pointer/count update
    // ------------------------------------------------------------------
    always_comb begin
        // A fence raised against a non-empty buffer blocks in the same
        // cycle; the registered hold keeps blocking after fence drops.
        hold_now  = fence_hold_q | (fence & (count_q != '0));

        // No same-cycle bypass: a full buffer refuses even if the head
        // retires this cycle.
        st_ready  = (count_q < CNT_W'(DEPTH)) & ~hold_now;
        mem_valid = (count_q != '0);

        st_fire   = st_valid & st_ready;
        // Stores with no byte enables are accepted but leave no entry.
        enq       = st_fire & (|st_we);
        deq       = mem_valid & mem_ready;

        head_d    = deq ? head_q + PTR_W'(1) : head_q;
        tail_d    = enq ? tail_q + PTR_W'(1) : tail_q;

        count_d   = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Hold releases in the same cycle the buffer reaches empty, so a
        // store held behind the fence is accepted as soon as empty = 1.
        fence_hold_d = hold_now & (count_d != '0);
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_we_d   = ent_we_q;
        if (enq) begin
            ent_addr_d[tail_q] = st_addr;
            ent_data_d[tail_q] = st_data;
            ent_we_d[tail_q]   = st_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            fence_hold_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
                ent_we_q[i]   <= '0;
            end
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            fence_hold_q <= fence_hold_d;
            ent_addr_q   <= ent_addr_d;
            ent_data_q   <= ent_data_d;
            ent_we_q     <= ent_we_d;
        end
    end

    // ------------------------------------------------------------------
    // Drain port and status
    // ------------------------------------------------------------------
    assign mem_addr = ent_addr_q[head_q];
    assign mem_din  = ent_data_q[head_q];
    assign mem_we   = ent_we_q[head_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

    // ------------------------------------------------------------------
    // Load lookup over registered entries only. Entries are walked from
    // oldest (head) to youngest so later matches overwrite earlier bytes,
    // leaving the youngest store's byte in each lane.
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  idx;
`ifdef STORE_FWD_EN
    logic [DATA_W-1:0] fwd_data;
`endif

    always_comb begin
        ld_mask  = '0;
        idx      = '0;
`ifdef STORE_FWD_EN
        fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (ent_addr_q[idx] == ld_addr)) begin
                ld_mask = ld_mask | ent_we_q[idx];
`ifdef STORE_FWD_EN
                for (int b = 0; b < NB; b++) begin
                    if (ent_we_q[idx][b]) begin
                        fwd_data[8*b +: 8] = ent_data_q[idx][8*b +: 8];
                    end
                end
`endif
            end
        end
    end

`ifdef STORE_FWD_EN
    assign ld_data     = fwd_data;
    assign ld_conflict = 1'b0;
`else
    assign ld_data     = '0;
    assign ld_conflict = |ld_mask;
`endif

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [13:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_we;
    logic        fence;
    logic [13:0] ld_addr;
    logic [3:0]  ld_mask;
    logic [31:0] ld_data;
    logic        ld_conflict;
    logic        mem_valid;
    logic        mem_ready;
    logic [13:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_we;
    logic        empty;
    logic [2:0]  count;

`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    store_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_we      (st_we),
        .fence      (fence),
        .ld_addr    (ld_addr),
        .ld_mask    (ld_mask),
        .ld_data    (ld_data),
        .ld_conflict(ld_conflict),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .empty      (empty),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: every accepted store with nonzero enables must later
    // appear on the drain port, in order, exactly once.
    // ------------------------------------------------------------------
    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (st_valid && st_ready && (st_we != 4'h0)) begin
                e.addr = st_addr;
                e.data = st_data;
                e.we   = st_we;
                sb.push_back(e);
            end
            if (mem_valid && mem_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected_write: got write to 0x%0h, expected no write at %0t",
                             mem_addr, $time);
                end else begin
                    e = sb.pop_front();
                    check("sb_mem_addr", 64'(mem_addr), 64'(e.addr));
                    check("sb_mem_din",  64'(mem_din),  64'(e.data));
                    check("sb_mem_we",   64'(mem_we),   64'(e.we));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Vector table: inputs for one cycle and the outputs expected in that
    // cycle (before the clock edge that acts on them).
    // ------------------------------------------------------------------
    typedef struct {
        logic        sv;
        logic [13:0] a;
        logic [31:0] d;
        logic [3:0]  we;
        logic        mr;
        logic [2:0]  c;
        logic        rdy;
        logic        mv;
        logic [13:0] ma;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic sv, input logic [13:0] a, input logic [31:0] d,
                       input logic [3:0] we, input logic mr, input logic [2:0] c,
                       input logic rdy, input logic mv, input logic [13:0] ma);
        vec_t v;
        v.sv = sv; v.a = a; v.d = d; v.we = we; v.mr = mr;
        v.c = c; v.rdy = rdy; v.mv = mv; v.ma = ma;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic sv, input logic [13:0] a, input logic [31:0] d,
                         input logic [3:0] we, input logic mr);
        st_valid  = sv;
        st_addr   = a;
        st_data   = d;
        st_we     = we;
        mem_ready = mr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;

        rst_n = 1'b0;
        fence = 1'b0;
        ld_addr = 14'h3fff;
        drive(0, 14'h0, 32'h0, 4'h0, 0);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",       64'(count),       64'd0);
        check("rst_mem_valid",   64'(mem_valid),   64'd0);
        check("rst_empty",       64'(empty),       64'd1);
        check("rst_ld_mask",     64'(ld_mask),     64'd0);
        check("rst_ld_conflict", 64'(ld_conflict), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_st_ready",    64'(st_ready),    64'd1);
        next_cycle();

        // ---------------- table-driven sequences ----------------
        // Fill 4 with mem stalled, then drain in order.
        add(1, 14'h10, 32'hA0, 4'hF, 0, 0, 1, 0, 14'h0);
        add(1, 14'h11, 32'hA1, 4'hF, 0, 1, 1, 1, 14'h10);
        add(1, 14'h12, 32'hA2, 4'hF, 0, 2, 1, 1, 14'h10);
        add(1, 14'h13, 32'hA3, 4'hF, 0, 3, 1, 1, 14'h10);
        add(0, 14'h0,  32'h0,  4'h0, 0, 4, 0, 1, 14'h10);
        add(0, 14'h0,  32'h0,  4'h0, 1, 4, 0, 1, 14'h10);
        add(0, 14'h0,  32'h0,  4'h0, 1, 3, 1, 1, 14'h11);
        add(0, 14'h0,  32'h0,  4'h0, 1, 2, 1, 1, 14'h12);
        add(0, 14'h0,  32'h0,  4'h0, 1, 1, 1, 1, 14'h13);
        add(0, 14'h0,  32'h0,  4'h0, 0, 0, 1, 0, 14'h0);
        // Store with no enables is accepted and discarded.
        add(1, 14'h40, 32'hDEADBEEF, 4'h0, 0, 0, 1, 0, 14'h0);
        add(0, 14'h0,  32'h0,  4'h0, 0, 0, 1, 0, 14'h0);
        // Full with simultaneous offer and drain: no enqueue 4->3, then enq+deq at 3.
        add(1, 14'h30, 32'hB0, 4'hF, 0, 0, 1, 0, 14'h0);
        add(1, 14'h31, 32'hB1, 4'hF, 0, 1, 1, 1, 14'h30);
        add(1, 14'h32, 32'hB2, 4'hF, 0, 2, 1, 1, 14'h30);
        add(1, 14'h33, 32'hB3, 4'hF, 0, 3, 1, 1, 14'h30);
        add(1, 14'h34, 32'hB4, 4'hF, 1, 4, 0, 1, 14'h30);
        add(1, 14'h34, 32'hB4, 4'hF, 1, 3, 1, 1, 14'h31);
        add(0, 14'h0,  32'h0,  4'h0, 1, 3, 1, 1, 14'h32);
        add(0, 14'h0,  32'h0,  4'h0, 1, 2, 1, 1, 14'h33);
        add(0, 14'h0,  32'h0,  4'h0, 1, 1, 1, 1, 14'h34);
        add(0, 14'h0,  32'h0,  4'h0, 0, 0, 1, 0, 14'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sv, tbl[i].a, tbl[i].d, tbl[i].we, tbl[i].mr);
            #1;
            check($sformatf("v%0d_count", i),     64'(count),     64'(tbl[i].c));
            check($sformatf("v%0d_st_ready", i),  64'(st_ready),  64'(tbl[i].rdy));
            check($sformatf("v%0d_mem_valid", i), 64'(mem_valid), 64'(tbl[i].mv));
            check($sformatf("v%0d_empty", i),     64'(empty),     64'(tbl[i].c == 3'd0));
            if (tbl[i].mv)
                check($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(tbl[i].ma));
            next_cycle();
        end

        // ---------------- load lookup / forwarding ----------------
        ld_addr = 14'h20;
        drive(1, 14'h20, 32'h11223344, 4'h3, 0);
        #1;
        check("ld_not_yet_visible", 64'(ld_mask), 64'h0);
        next_cycle();
        drive(1, 14'h20, 32'hAABBCCDD, 4'h6, 0);
        #1;
        check("ld_mask_one", 64'(ld_mask), 64'h3);
        next_cycle();
        drive(0, 14'h0, 32'h0, 4'h0, 0);
        #1;
        check("ld_mask_two",     64'(ld_mask),                  64'h7);
        check("ld_data_fwd",     64'(ld_data & 32'h00FFFFFF),   FWD ? 64'h00BBCC44 : 64'h0);
        check("ld_conflict_two", 64'(ld_conflict),              FWD ? 64'd0 : 64'd1);
        ld_addr = 14'h21;
        #1;
        check("ld_miss_mask",     64'(ld_mask),     64'h0);
        check("ld_miss_conflict", 64'(ld_conflict), 64'd0);
        ld_addr = 14'h20;
        mem_ready = 1'b1;
        #1;
        check("ld_conflict_pre_deq", 64'(ld_conflict), FWD ? 64'd0 : 64'd1);
        next_cycle();
        check("ld_count_one",       64'(count),                  64'd1);
        check("ld_mask_after_deq",  64'(ld_mask),                64'h6);
        check("ld_data_after_deq",  64'(ld_data & 32'h00FFFF00), FWD ? 64'h00BBCC00 : 64'h0);
        check("ld_conflict_mid",    64'(ld_conflict),            FWD ? 64'd0 : 64'd1);
        next_cycle();
        check("ld_count_zero",      64'(count),       64'd0);
        check("ld_mask_drained",    64'(ld_mask),     64'h0);
        check("ld_conflict_clear",  64'(ld_conflict), 64'd0);
        mem_ready = 1'b0;
        ld_addr = 14'h3fff;

        // ---------------- fence ----------------
        drive(1, 14'h60, 32'hC0, 4'hF, 0);
        next_cycle();
        drive(1, 14'h61, 32'hC1, 4'hF, 0);
        next_cycle();
        drive(1, 14'h50, 32'h55, 4'hF, 0);
        fence = 1'b1;
        #1;
        check("fence_count",      64'(count),    64'd2);
        check("fence_rdy_raise",  64'(st_ready), 64'd0);
        next_cycle();
        fence = 1'b0;
        mem_ready = 1'b1;
        #1;
        waited = 0;
        while (!empty && waited < 8) begin
            check("fence_rdy_hold", 64'(st_ready), 64'd0);
            next_cycle();
            waited++;
        end
        check("fence_drain_done",  64'(empty),    64'd1);
        check("fence_rdy_release", 64'(st_ready), 64'd1);
        next_cycle();
        st_valid = 1'b0;
        #1;
        check("fence_held_accepted", 64'(count),    64'd1);
        check("fence_held_addr",     64'(mem_addr), 64'h50);
        next_cycle();
        check("fence_final_empty",   64'(empty),    64'd1);
        mem_ready = 1'b0;

        // ---------------- reset mid-drain ----------------
        for (int i = 0; i < 4; i++) begin
            drive(1, 14'(14'h70 + i), 32'(32'hE0 + i), 4'hF, 0);
            next_cycle();
        end
        drive(0, 14'h0, 32'h0, 4'h0, 1);
        #1;
        check("mid_count_full", 64'(count), 64'd4);
        next_cycle();
        check("mid_count_three", 64'(count),     64'd3);
        check("mid_mem_valid",   64'(mem_valid), 64'd1);
        rst_n = 1'b0;
        sb.delete();
        ld_addr = 14'h71;
        #1;
        check("mid_rst_mem_valid", 64'(mem_valid), 64'd0);
        check("mid_rst_count",     64'(count),     64'd0);
        check("mid_rst_ld_mask",   64'(ld_mask),   64'h0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check("post_rst_mem_valid", 64'(mem_valid), 64'd0);
            check("post_rst_empty",     64'(empty),     64'd1);
            check("post_rst_count",     64'(count),     64'd0);
            check("post_rst_st_ready",  64'(st_ready),  64'd1);
        end
        mem_ready = 1'b0;
        next_cycle();
        check("sb_all_retired", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
